// File: rtl/main_mem_pipe_if.sv
// main_mem_pipe_if: Wishbone bundle between a bus master and the main_mem_pipe slave.
// Latency: none (wires only).
// Backpressure: master holds cyc/stb until o_wb_ack or o_wb_err; slave ignores stb while busy.
// Signals: i_wb_* are driven by the master, o_wb_* by the slave (names seen from the slave).
interface main_mem_pipe_if #(
  parameter int WB_DWIDTH = 32,
  parameter int WB_SWIDTH = 4
);
  logic [31:0]          i_wb_adr;
  logic [WB_SWIDTH-1:0] i_wb_sel;
  logic                 i_wb_we;
  logic [WB_DWIDTH-1:0] i_wb_dat;
  logic                 i_wb_cyc;
  logic                 i_wb_stb;
  logic [WB_DWIDTH-1:0] o_wb_dat;
  logic                 o_wb_ack;
  logic                 o_wb_err;

  modport master (
    output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );

  modport slave (
    input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/main_mem_pipe.sv
// main_mem_pipe: simulation main memory, 128-bit line store behind a 32- or 128-bit Wishbone port.
// Latency: write ack (or range error) at accept+1; read ack+data at accept+RD_LATENCY.
// Backpressure: one access in flight, stb ignored until the cycle after ack/err; a read aborts if stb/cyc drop.
// Ports: i_clk; i_rst_n (async, active low); i_mem_ctrl (1 = 32 MB window); wb (slave modport).
// Option: define MAIN_MEM_RANGE_ERR_EN to answer out-of-window accesses with o_wb_err instead of wrapping.
module main_mem_pipe #(
  parameter int WB_DWIDTH  = 32,
  parameter int WB_SWIDTH  = 4,
  parameter int MEM_AW     = 23,
  parameter int RD_LATENCY = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_mem_ctrl,
  main_mem_pipe_if.slave wb
);

  if (!(WB_DWIDTH == 32 || WB_DWIDTH == 128)) begin : g_bad_dwidth
    $fatal(1, "main_mem_pipe: WB_DWIDTH must be 32 or 128");
  end
  if (WB_SWIDTH != WB_DWIDTH / 8) begin : g_bad_swidth
    $fatal(1, "main_mem_pipe: WB_SWIDTH must equal WB_DWIDTH/8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
    $fatal(1, "main_mem_pipe: RD_LATENCY must be 1..15");
  end
  if (MEM_AW < 1 || MEM_AW > 28) begin : g_bad_aw
    $fatal(1, "main_mem_pipe: MEM_AW must be 1..28");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RESP = 2'd1;  // the single ack/err cycle
  localparam logic [1:0] ST_READ = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [MEM_AW-1:0]    idx_q, idx_d;
  logic [1:0]           lane_q, lane_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [WB_DWIDTH-1:0] dat_q, dat_d;

  logic [127:0] mem [2**MEM_AW];

  logic                 req;
  logic [MEM_AW-1:0]    acc_idx;
  logic [1:0]           acc_lane;
  logic [MEM_AW-1:0]    rd_idx;
  logic [1:0]           rd_lane;
  logic [127:0]         rd_line;
  logic [WB_DWIDTH-1:0] rd_word;
  logic [15:0]          wr_en;
  logic [127:0]         wr_line;
  logic [127:0]         merged;
  logic                 wr_commit;
  logic                 range_err;
  logic                 unused_adr;

  assign req      = wb.i_wb_cyc & wb.i_wb_stb;
  assign acc_lane = wb.i_wb_adr[3:2];
  // Byte offset and bits outside the decoded window are deliberately dropped.
  assign unused_adr = ^wb.i_wb_adr;

  // Line index; the 32 MB window clears index bits that sit above byte address bit 24.
  always_comb begin
    acc_idx = wb.i_wb_adr[MEM_AW+3:4];
    if (i_mem_ctrl) begin
      for (int i = 21; i < MEM_AW; i++) acc_idx[i] = 1'b0;
    end
  end

`ifdef MAIN_MEM_RANGE_ERR_EN
  logic [32:0] win_size;
  assign win_size  = i_mem_ctrl ? 33'h0_0200_0000 : (33'd1 << (MEM_AW + 4));
  assign range_err = {1'b0, wb.i_wb_adr} >= win_size;
`else
  assign range_err = 1'b0;
`endif

  // In IDLE the line read serves the write merge / latency-1 read of the request on the bus;
  // during READ it follows the latched index.
  assign rd_idx  = (state_q == ST_IDLE) ? acc_idx  : idx_q;
  assign rd_lane = (state_q == ST_IDLE) ? acc_lane : lane_q;
  assign rd_line = mem[rd_idx];

  if (WB_DWIDTH == 32) begin : g_w32
    assign wr_en   = {12'b0, wb.i_wb_sel} << {acc_lane, 2'b00};
    assign wr_line = {4{wb.i_wb_dat}};
    assign rd_word = rd_line[32*rd_lane +: 32];
  end else begin : g_w128
    assign wr_en   = wb.i_wb_sel;
    assign wr_line = wb.i_wb_dat;
    assign rd_word = rd_line;
  end

  always_comb begin
    merged = rd_line;
    for (int b = 0; b < 16; b++) begin
      if (wr_en[b]) merged[8*b +: 8] = wr_line[8*b +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;
    wr_commit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d  = acc_idx;
          lane_d = acc_lane;
          if (range_err) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (wb.i_wb_we) begin
            // The write lands on the same edge that raises ack.
            wr_commit = 1'b1;
            ack_d     = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cnt_d   = 4'(RD_LATENCY - 1);
            state_d = ST_READ;
            if (RD_LATENCY == 1) begin
              ack_d = 1'b1;
              dat_d = rd_word;
            end
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_READ: begin
        // cnt_q == 0 is the ack cycle itself; the master may release stb there.
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            ack_d = 1'b1;
            dat_d = rd_word;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Storage survives reset.
  always_ff @(posedge i_clk) begin
    if (wr_commit) mem[acc_idx] <= merged;
  end

  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_err = err_q;
  assign wb.o_wb_dat = dat_q;

endmodule

// File: tb/tb_main_mem_pipe.sv
// tb_main_mem_pipe: directed bench for main_mem_pipe with a transaction-level memory model.
// Latency: n/a.
// Backpressure: n/a.
// Two instances: 32-bit port (MEM_AW=22, RD_LATENCY=4) and 128-bit port (MEM_AW=10, RD_LATENCY=3).
module tb_main_mem_pipe;

  logic clk;
  logic rst32_n, rst128_n;
  logic mctrl32, mctrl128;

  main_mem_pipe_if #(.WB_DWIDTH(32),  .WB_SWIDTH(4))  bus32 ();
  main_mem_pipe_if #(.WB_DWIDTH(128), .WB_SWIDTH(16)) bus128 ();

  main_mem_pipe #(.WB_DWIDTH(32), .WB_SWIDTH(4), .MEM_AW(22), .RD_LATENCY(4)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst32_n), .i_mem_ctrl(mctrl32), .wb(bus32)
  );
  main_mem_pipe #(.WB_DWIDTH(128), .WB_SWIDTH(16), .MEM_AW(10), .RD_LATENCY(3)) u_dut128 (
    .i_clk(clk), .i_rst_n(rst128_n), .i_mem_ctrl(mctrl128), .wb(bus128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint now    = 0;
  bit     run    = 1'b0;

  always @(posedge clk) now <= now + 1;

  // Model: sparse line stores plus the single outstanding response per port.
  logic [127:0] m0 [longint];
  logic [127:0] m1 [longint];
  bit           pend_v   [2];
  bit           pend_err [2];
  bit           pend_rd  [2];
  longint       pend_at  [2];
  logic [127:0] pend_dat [2];
  logic [127:0] hold_dat [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int aw_of(input int k);
    return (k == 0) ? 22 : 10;
  endfunction

  function automatic bit mc_of(input int k);
    return (k == 0) ? mctrl32 : mctrl128;
  endfunction

  function automatic longint line_of(input int k, input logic [31:0] adr, input bit mc);
    longint a;
    a = longint'(adr);
    if (mc) a = a % (longint'(1) << 25);
    return (a >> 4) % (longint'(1) << aw_of(k));
  endfunction

  function automatic bit out_of_win(input int k, input logic [31:0] adr, input bit mc);
    bit r;
    r = 1'b0;
`ifdef MAIN_MEM_RANGE_ERR_EN
    r = longint'(adr) >= (mc ? (longint'(1) << 25) : (longint'(1) << (aw_of(k) + 4)));
`endif
    return r;
  endfunction

  function automatic logic [127:0] m_rd(input int k, input longint ln);
    if (k == 0) return m0.exists(ln) ? m0[ln] : 128'b0;
    return m1.exists(ln) ? m1[ln] : 128'b0;
  endfunction

  task automatic m_wr(input int k, input longint ln, input logic [127:0] v);
    if (k == 0) m0[ln] = v;
    else        m1[ln] = v;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, now, act, exp);
    end
  endtask

  task automatic cmp_port(input int k, input logic [127:0] dat, input logic ack, input logic err);
    bit           hit;
    logic [127:0] e_dat;
    hit   = pend_v[k] && (pend_at[k] == now);
    e_dat = (hit && pend_rd[k]) ? pend_dat[k] : hold_dat[k];
    chk((k == 0) ? "ack32" : "ack128", {127'b0, ack}, {127'b0, hit && !pend_err[k]});
    chk((k == 0) ? "err32" : "err128", {127'b0, err}, {127'b0, hit && pend_err[k]});
    chk((k == 0) ? "dat32" : "dat128", dat, e_dat);
    if (hit) begin
      hold_dat[k] = e_dat;
      pend_v[k]   = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        cmp_port(0, {96'b0, bus32.o_wb_dat}, bus32.o_wb_ack, bus32.o_wb_err);
        cmp_port(1, bus128.o_wb_dat, bus128.o_wb_ack, bus128.o_wb_err);
      end
    end
  end

  task automatic drive(input int k, input bit act, input bit we, input logic [31:0] adr,
                       input logic [15:0] sel, input logic [127:0] dat);
    if (k == 0) begin
      bus32.i_wb_cyc = act;  bus32.i_wb_stb = act;  bus32.i_wb_we = we;
      bus32.i_wb_adr = adr;  bus32.i_wb_sel = sel[3:0]; bus32.i_wb_dat = dat[31:0];
    end else begin
      bus128.i_wb_cyc = act; bus128.i_wb_stb = act; bus128.i_wb_we = we;
      bus128.i_wb_adr = adr; bus128.i_wb_sel = sel;  bus128.i_wb_dat = dat;
    end
  endtask

  // One complete access; the model schedules the response, the compare process checks it.
  task automatic acc(input int k, input bit we, input logic [31:0] adr, input logic [15:0] sel,
                     input logic [127:0] dat, output logic [127:0] got);
    longint       ln;
    int           lane;
    int           lat;
    logic [127:0] line;
    bit           en;
    @(negedge clk); #1;
    drive(k, 1'b1, we, adr, sel, dat);
    ln   = line_of(k, adr, mc_of(k));
    lane = (k == 0) ? int'(adr[3:2]) : 0;
    line = m_rd(k, ln);
    pend_v[k]   = 1'b1;
    pend_err[k] = 1'b0;
    pend_rd[k]  = 1'b0;
    if (out_of_win(k, adr, mc_of(k))) begin
      pend_err[k] = 1'b1;
      lat = 1;
    end else if (we) begin
      for (int b = 0; b < 16; b++) begin
        en = (k == 0) ? ((b / 4 == lane) && sel[b % 4]) : sel[b];
        if (en) line[8*b +: 8] = dat[8*((k == 0) ? (b % 4) : b) +: 8];
      end
      m_wr(k, ln, line);
      lat = 1;
    end else begin
      pend_rd[k]  = 1'b1;
      pend_dat[k] = (k == 0) ? ((line >> (32 * lane)) & 128'hFFFF_FFFF) : line;
      lat = lat_of(k);
    end
    pend_at[k] = now + lat;
    repeat (lat) @(negedge clk);
    #1;
    got = (k == 0) ? {96'b0, bus32.o_wb_dat} : bus128.o_wb_dat;
    drive(k, 1'b0, 1'b0, 32'h0, 16'h0, 128'h0);
  endtask

  task automatic rd_abort(input int k, input logic [31:0] adr);
    @(negedge clk); #1;
    drive(k, 1'b1, 1'b0, adr, 16'hFFFF, 128'h0);
    @(negedge clk); #1;
    drive(k, 1'b0, 1'b0, 32'h0, 16'h0, 128'h0);
    repeat (lat_of(k) + 2) @(negedge clk);
  endtask

  task automatic rd_reset128(input logic [31:0] adr);
    @(negedge clk); #1;
    drive(1, 1'b1, 1'b0, adr, 16'hFFFF, 128'h0);
    @(negedge clk); #1;
    rst128_n = 1'b0;
    drive(1, 1'b0, 1'b0, 32'h0, 16'h0, 128'h0);
    pend_v[1]   = 1'b0;
    hold_dat[1] = 128'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_ack", {127'b0, bus128.o_wb_ack}, 128'h0);
    chk("rst_mid_dat", bus128.o_wb_dat, 128'h0);
    rst128_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [127:0] got, dmy, exp5;

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend_v[k] = 1'b0; pend_err[k] = 1'b0; pend_rd[k] = 1'b0;
      pend_at[k] = 0;   pend_dat[k] = '0;   hold_dat[k] = '0;
    end
    rst32_n = 1'b1; rst128_n = 1'b1; mctrl32 = 1'b0; mctrl128 = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 16'h0, 128'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 16'h0, 128'h0);
    #1;
    rst32_n = 1'b0; rst128_n = 1'b0;
    #1 run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst32_n = 1'b1; rst128_n = 1'b1;
    chk("rst_ack32", {127'b0, bus32.o_wb_ack}, 128'h0);
    chk("rst_err32", {127'b0, bus32.o_wb_err}, 128'h0);
    chk("rst_dat32", {96'b0, bus32.o_wb_dat}, 128'h0);
    chk("rst_dat128", bus128.o_wb_dat, 128'h0);

    // 32-bit write/read and lane isolation
    acc(0, 1'b1, 32'h0000_0104, 16'h000F, 128'hDEAD_BEEF, dmy);
    acc(0, 1'b0, 32'h0000_0104, 16'h000F, 128'h0, got);
    chk("t2_read", got, 128'hDEAD_BEEF);
    acc(0, 1'b1, 32'h0000_0108, 16'h000F, 128'hCAFE_F00D, dmy);
    acc(0, 1'b0, 32'h0000_0104, 16'h000F, 128'h0, got);
    chk("lane_isolation", got, 128'hDEAD_BEEF);

    // partial byte enable, sel=0 write, ignored adr[1:0]
    acc(0, 1'b1, 32'h0000_0200, 16'h000F, 128'h1122_3344, dmy);
    acc(0, 1'b1, 32'h0000_0200, 16'h0002, 128'h0000_AA00, dmy);
    acc(0, 1'b0, 32'h0000_0200, 16'h000F, 128'h0, got);
    chk("t3_byte_merge", got, 128'h1122_AA44);
    acc(0, 1'b1, 32'h0000_0200, 16'h0000, 128'hFFFF_FFFF, dmy);
    acc(0, 1'b0, 32'h0000_0203, 16'h000F, 128'h0, got);
    chk("sel0_write", got, 128'h1122_AA44);

    // 128-bit partial line write
    acc(1, 1'b1, 32'h0, 16'hFFFF, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, dmy);
    acc(1, 1'b1, 32'h10, 16'hFFFF, 128'hA5A5_A5A5_0000_1111_2222_3333_4444_5555, dmy);
    acc(1, 1'b1, 32'h0, 16'h00FF, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, dmy);
    acc(1, 1'b0, 32'h5, 16'h0, 128'h0, got);
    chk("t4_line", got, 128'h0011_2233_4455_6677_0F0F_0F0F_0F0F_0F0F);
    acc(1, 1'b0, 32'h10, 16'h0, 128'h0, got);
    chk("t4_other_line", got, 128'hA5A5_A5A5_0000_1111_2222_3333_4444_5555);

    // reset in the middle of a 128-bit read; memory must survive
    rd_reset128(32'h0);
    acc(1, 1'b0, 32'h0, 16'h0, 128'h0, got);
    chk("t1_mem_intact", got, 128'h0011_2233_4455_6677_0F0F_0F0F_0F0F_0F0F);

    // address window
    acc(0, 1'b1, 32'h0000_0010, 16'h000F, 128'h1357_9BDF, dmy);
    mctrl32 = 1'b1;
    acc(0, 1'b1, 32'h0200_0010, 16'h000F, 128'h5A5A_5A5A, dmy);
    acc(0, 1'b0, 32'h0000_0010, 16'h000F, 128'h0, got);
    exp5 = 128'h5A5A_5A5A;
`ifdef MAIN_MEM_RANGE_ERR_EN
    exp5 = 128'h1357_9BDF;
`endif
    chk("t5_window", got, exp5);
    mctrl32 = 1'b0;
    acc(0, 1'b1, 32'h0200_0010, 16'h000F, 128'h7788_99AA, dmy);
    acc(0, 1'b0, 32'h0200_0010, 16'h000F, 128'h0, got);
    chk("full_window_rd", got, 128'h7788_99AA);
    acc(0, 1'b0, 32'h0000_0010, 16'h000F, 128'h0, got);
    chk("full_window_sep", got, exp5);
    acc(0, 1'b0, 32'h0400_0010, 16'h000F, 128'h0, got);

    // read abort then an immediate write
    rd_abort(0, 32'h0000_0104);
    acc(0, 1'b1, 32'h0000_0104, 16'h000F, 128'h0BAD_CAFE, dmy);
    acc(0, 1'b0, 32'h0000_0104, 16'h000F, 128'h0, got);
    chk("t6_after_abort", got, 128'h0BAD_CAFE);

    repeat (3) @(negedge clk);
    #1 run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
